add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter_pkg.sv | 27 ++
 rtl/add_arbiter_core.sv | 14 +
 rtl/add_arbiter.sv | 123 ++++++++++++
 tb/tb_add_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_arbiter_pkg.sv
// Shared types and constants for the two-requester add arbiter.
package add_arbiter_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  typedef logic req_id_t;

  // Round-robin pick: a lone requester wins, a tie goes to the one not granted last.
  function automatic req_id_t rr_pick(input logic v0, input logic v1, input req_id_t last);
    req_id_t win;
    if (v0 && v1) begin
      win = ~last;
    end else if (v1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    return win;
  endfunction

endpackage

// File: rtl/add_arbiter_core.sv
// Shared combinational WIDTH-bit adder with carry-out.
module add_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  // Widen both operands by one bit so the carry falls out of the top.
  assign {carry_o, sum_o} = (WIDTH+1)'(a_i) + (WIDTH+1)'(b_i);

endmodule

// File: rtl/add_arbiter.sv
// Two-requester round-robin arbiter in front of one shared adder, with a
// single-entry result register. Optional handshake counter enabled by the
// macro ADD_ARBITER_TXN_CNT_EN.
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH:0]   res_sum,
  output logic             res_id,
  input  logic             res_ready,
  output logic [CNT_W-1:0] txn_count
);

  state_e           state_q, state_d;
  req_id_t          last_q, last_d;
  logic [WIDTH:0]   sum_q, sum_d;
  req_id_t          id_q, id_d;

  req_id_t          winner_c;
  logic             slot_free_c;
  logic             grant_en_c;
  logic             grant_c;
  logic             drain_c;
  logic [WIDTH-1:0] op_a_c, op_b_c;
  logic [WIDTH-1:0] add_sum_c;
  logic             add_carry_c;

  // Arbitration: readys are gated by reset so nothing is accepted while held.
  assign winner_c    = rr_pick(req0_valid, req1_valid, last_q);
  assign slot_free_c = (state_q == ST_EMPTY) || res_ready;
  assign grant_en_c  = rst_n && ena && slot_free_c;
  assign grant_c     = grant_en_c && (req0_valid || req1_valid);
  assign drain_c     = (state_q == ST_FULL) && res_ready;
  assign req0_ready  = grant_en_c && req0_valid && (winner_c == 1'b0);
  assign req1_ready  = grant_en_c && req1_valid && (winner_c == 1'b1);

  // Operand steering into the single adder.
  assign op_a_c = winner_c ? req1_a : req0_a;
  assign op_b_c = winner_c ? req1_b : req0_b;

  add_core #(
    .WIDTH (WIDTH)
  ) u_add_core (
    .a_i     (op_a_c),
    .b_i     (op_b_c),
    .sum_o   (add_sum_c),
    .carry_o (add_carry_c)
  );

  // Next-state: a grant (re)fills the slot, a drain without grant empties it.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sum_d   = sum_q;
    id_d    = id_q;
    if (grant_c) begin
      state_d = ST_FULL;
      sum_d   = {add_carry_c, add_sum_c};
      id_d    = winner_c;
      last_d  = winner_c;
    end else if (drain_c) begin
      state_d = ST_EMPTY;
    end
  end

  // State register; last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      last_q  <= 1'b1;
      sum_q   <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
    end
  end

  assign res_valid = (state_q == ST_FULL);
  assign res_sum   = sum_q;
  assign res_id    = id_q;

`ifdef ADD_ARBITER_TXN_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count every result handshake, wrapping modulo 256.
  always_comb begin
    cnt_d = cnt_q;
    if (drain_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign txn_count = cnt_q;
`else
  assign txn_count = '0;
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// Directed self-checking bench for add_arbiter (WIDTH=8).
module tb_add_arbiter;

  localparam int unsigned W = 8;
`ifdef ADD_ARBITER_TXN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         res_valid;
  logic [W:0]   res_sum;
  logic         res_id;
  logic         res_ready;
  logic [7:0]   txn_count;

  int tests_run    = 0;
  int tests_failed = 0;

  add_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_sum    (res_sum),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .txn_count  (txn_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; res_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd1;
    req1_valid = 1'b1; req1_a = 8'd2; req1_b = 8'd2;
    #1;
    tests_run++;
    if (req0_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_r0_ready: got %b expected 0", req0_ready); end
    tests_run++;
    if (req1_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_r1_ready: got %b expected 0", req1_ready); end
    step();
    tests_run++;
    if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b expected 0", res_valid); end
    tests_run++;
    if (res_sum !== 9'd0) begin tests_failed++; $display("FAIL rst_sum: got %0d expected 0", res_sum); end
    tests_run++;
    if (res_id !== 1'b0) begin tests_failed++; $display("FAIL rst_id: got %b expected 0", res_id); end
    tests_run++;
    if (txn_count !== 8'd0) begin tests_failed++; $display("FAIL rst_txn: got %0d expected 0", txn_count); end
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd4;
    req1_valid = 1'b0; res_ready = 1'b1; ena = 1'b1;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1) begin tests_failed++; $display("FAIL single_r0_ready: got %b expected 1", req0_ready); end
    tests_run++;
    if (req1_ready !== 1'b0) begin tests_failed++; $display("FAIL single_r1_ready: got %b expected 0", req1_ready); end
    step();
    req0_valid = 1'b0;
    tests_run++;
    if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %b expected 1", res_valid); end
    tests_run++;
    if (res_sum !== 9'd7) begin tests_failed++; $display("FAIL single_sum: got %0d expected 7", res_sum); end
    tests_run++;
    if (res_id !== 1'b0) begin tests_failed++; $display("FAIL single_id: got %b expected 0", res_id); end
    step();
    tests_run++;
    if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL single_drain: got %b expected 0", res_valid); end
  endtask

  task automatic test_round_robin();
    logic       w;
    logic [W:0] exp_sum;
    do_reset();
    res_ready = 1'b1; ena = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = 1'(i % 2);
      req0_valid = 1'b1; req0_a = 8'(10 + i); req0_b = 8'd1;
      req1_valid = 1'b1; req1_a = 8'(100 + i); req1_b = 8'd2;
      exp_sum = w ? 9'(102 + i) : 9'(11 + i);
      #1;
      tests_run++;
      if (req0_ready !== ~w) begin tests_failed++; $display("FAIL rr_r0_ready[%0d]: got %b expected %b", i, req0_ready, ~w); end
      tests_run++;
      if (req1_ready !== w) begin tests_failed++; $display("FAIL rr_r1_ready[%0d]: got %b expected %b", i, req1_ready, w); end
      step();
      tests_run++;
      if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL rr_valid[%0d]: got %b expected 1", i, res_valid); end
      tests_run++;
      if (res_id !== w) begin tests_failed++; $display("FAIL rr_id[%0d]: got %b expected %b", i, res_id, w); end
      tests_run++;
      if (res_sum !== exp_sum) begin tests_failed++; $display("FAIL rr_sum[%0d]: got %0d expected %0d", i, res_sum, exp_sum); end
    end
    tests_run++;
    if (txn_count !== (CNT_EN ? 8'd3 : 8'd0)) begin
      tests_failed++; $display("FAIL rr_txn: got %0d expected %0d", txn_count, CNT_EN ? 3 : 0);
    end
  endtask

  task automatic test_back_pressure();
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'd20; req0_b = 8'd5;
    req1_valid = 1'b1; req1_a = 8'd30; req1_b = 8'd6;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        tests_failed++; $display("FAIL bp_readys[%0d]: got %b expected 00", i, {req0_ready, req1_ready});
      end
      step();
      tests_run++;
      if (res_valid !== 1'b1 || res_sum !== 9'd105 || res_id !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got v=%b sum=%0d id=%b expected v=1 sum=105 id=1", i, res_valid, res_sum, res_id);
      end
    end
    res_ready = 1'b1;
    #1;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      tests_failed++; $display("FAIL bp_release_readys: got %b expected 10", {req0_ready, req1_ready});
    end
    step();
    tests_run++;
    if (res_valid !== 1'b1 || res_sum !== 9'd25 || res_id !== 1'b0) begin
      tests_failed++; $display("FAIL bp_release: got v=%b sum=%0d id=%b expected v=1 sum=25 id=0", res_valid, res_sum, res_id);
    end
    tests_run++;
    if (txn_count !== (CNT_EN ? 8'd4 : 8'd0)) begin
      tests_failed++; $display("FAIL bp_txn: got %0d expected %0d", txn_count, CNT_EN ? 4 : 0);
    end
  endtask

  task automatic test_boundary();
    res_ready = 1'b1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF;
    #1;
    tests_run++;
    if (req0_ready !== 1'b1) begin tests_failed++; $display("FAIL bnd_r0_ready: got %b expected 1", req0_ready); end
    step();
    tests_run++;
    if (res_sum !== 9'h1FE || res_id !== 1'b0) begin
      tests_failed++; $display("FAIL bnd_max: got sum=%0h id=%b expected sum=1fe id=0", res_sum, res_id);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h01;
    step();
    tests_run++;
    if (res_sum !== 9'h100 || res_id !== 1'b1) begin
      tests_failed++; $display("FAIL bnd_carry: got sum=%0h id=%b expected sum=100 id=1", res_sum, res_id);
    end
    req1_a = 8'h00; req1_b = 8'h00;
    step();
    tests_run++;
    if (res_valid !== 1'b1 || res_sum !== 9'h000) begin
      tests_failed++; $display("FAIL bnd_zero: got v=%b sum=%0h expected v=1 sum=0", res_valid, res_sum);
    end
  endtask

  task automatic test_enable();
    ena = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'd9; req0_b = 8'd9;
    req1_valid = 1'b1; req1_a = 8'd7; req1_b = 8'd7;
    #1;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      tests_failed++; $display("FAIL ena_readys_full: got %b expected 00", {req0_ready, req1_ready});
    end
    step();
    tests_run++;
    if (res_valid !== 1'b1 || res_sum !== 9'd0) begin
      tests_failed++; $display("FAIL ena_hold: got v=%b sum=%0d expected v=1 sum=0", res_valid, res_sum);
    end
    res_ready = 1'b1;
    #1;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      tests_failed++; $display("FAIL ena_readys_drain: got %b expected 00", {req0_ready, req1_ready});
    end
    step();
    tests_run++;
    if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL ena_drain: got %b expected 0", res_valid); end
    step();
    tests_run++;
    if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL ena_no_grant: got %b expected 0", res_valid); end
    tests_run++;
    if (txn_count !== (CNT_EN ? 8'd8 : 8'd0)) begin
      tests_failed++; $display("FAIL ena_txn: got %0d expected %0d", txn_count, CNT_EN ? 8 : 0);
    end
    ena = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_valid_drop();
    do_reset();
    ena = 1'b1; res_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd1;
    req1_valid = 1'b1; req1_a = 8'd2; req1_b = 8'd2;
    step();
    tests_run++;
    if (res_id !== 1'b0 || res_sum !== 9'd2) begin
      tests_failed++; $display("FAIL drop_first: got id=%b sum=%0d expected id=0 sum=2", res_id, res_sum);
    end
    res_ready = 1'b0; req0_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if (req1_ready !== 1'b0) begin tests_failed++; $display("FAIL drop_r1_ready[%0d]: got %b expected 0", i, req1_ready); end
      step();
    end
    req1_valid = 1'b0; res_ready = 1'b1;
    step();
    tests_run++;
    if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL drop_drain: got %b expected 0", res_valid); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      tests_failed++; $display("FAIL drop_tie_readys: got %b expected 01", {req0_ready, req1_ready});
    end
    step();
    tests_run++;
    if (res_id !== 1'b1 || res_sum !== 9'd4) begin
      tests_failed++; $display("FAIL drop_tie: got id=%b sum=%0d expected id=1 sum=4", res_id, res_sum);
    end
  endtask

  task automatic test_reset_mid();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 8'd5; req0_b = 8'd5;
    step();
    tests_run++;
    if (res_id !== 1'b0 || res_sum !== 9'd10) begin
      tests_failed++; $display("FAIL mid_setup: got id=%b sum=%0d expected id=0 sum=10", res_id, res_sum);
    end
    rst_n = 1'b0; res_ready = 1'b1;
    req1_valid = 1'b1; req1_a = 8'd6; req1_b = 8'd6;
    #1;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      tests_failed++; $display("FAIL mid_readys: got %b expected 00", {req0_ready, req1_ready});
    end
    step();
    tests_run++;
    if (res_valid !== 1'b0 || res_sum !== 9'd0 || res_id !== 1'b0) begin
      tests_failed++; $display("FAIL mid_cleared: got v=%b sum=%0d id=%b expected v=0 sum=0 id=0", res_valid, res_sum, res_id);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      tests_failed++; $display("FAIL mid_tie_readys: got %b expected 10", {req0_ready, req1_ready});
    end
    step();
    tests_run++;
    if (res_id !== 1'b0 || res_sum !== 9'd10) begin
      tests_failed++; $display("FAIL mid_tie: got id=%b sum=%0d expected id=0 sum=10", res_id, res_sum);
    end
  endtask

  task automatic test_txn_count();
    logic [7:0] exp_cnt;
    do_reset();
    ena = 1'b1; res_ready = 1'b1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd1;
    for (int k = 1; k <= 257; k++) begin
      step();
      exp_cnt = CNT_EN ? 8'((k - 1) % 256) : 8'd0;
      tests_run++;
      if (txn_count !== exp_cnt) begin
        tests_failed++; $display("FAIL txn_step[%0d]: got %0d expected %0d", k, txn_count, exp_cnt);
      end
    end
    req0_valid = 1'b0;
    step();
    tests_run++;
    if (txn_count !== (CNT_EN ? 8'd1 : 8'd0)) begin
      tests_failed++; $display("FAIL txn_wrap: got %0d expected %0d", txn_count, CNT_EN ? 1 : 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_boundary();
    test_enable();
    test_valid_drop();
    test_reset_mid();
    test_txn_count();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
